mix_sequencer: RTL and testbench
================================

// Module: mix_sequencer
// PURPOSE
//  Sequences the shared multiply-accumulate unit inside the DSP core for one N_IN x N_OUT gain matrix per audio frame.
//  Triggered by the ADAT output frame request (start); issues one tap per cycle: coefficient address, input select and MAC enable/clear.
//  Emits a delayed output-write strobe per output channel and flags frame overruns.
//  Runs in the slow DSP clock domain (~49.152 MHz; 1024 cycles per 48 kHz frame).
// PARAMETERS
//  N_IN         8  input channels per mix bus (>=2)
//  N_OUT        8  output buses (>=1)
//  MAC_LATENCY  2  cycles from mac_en to accumulator result valid (>=1)
// PORTS
//  clk        in   1                      DSP clock
//  reset      in   1                      synchronous, active-high
//  start      in   1                      one-cycle frame-start pulse
//  busy       out  1                      high while a frame is being sequenced
//  coef_addr  out  $clog2(N_IN*N_OUT)     coefficient RAM address = o*N_IN+i
//  in_sel     out  $clog2(N_IN)           input channel operand select = i
//  mac_en     out  1                      accumulate this cycle
//  mac_clear  out  1                      load instead of accumulate (first tap of a bus)
//  out_wr     out  1                      accumulator result valid, write to output out_sel
//  out_sel    out  $clog2(N_OUT)          output bus index for out_wr
//  done       out  1                      one-cycle pulse with the final out_wr of a frame
//  overrun    out  1                      sticky: start seen while busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters i=o=0, delay pipeline flushed.
//  States: IDLE -> RUN on start; RUN -> DRAIN after tap (o=N_OUT-1, i=N_IN-1);
//  DRAIN -> IDLE after MAC_LATENCY cycles. busy = (state != IDLE), registered.
//  Start at cycle 0 in IDLE: taps k=0..N_IN*N_OUT-1 issued at cycles 1..N_IN*N_OUT.
//  Per RUN cycle: mac_en=1, coef_addr=o*N_IN+i, in_sel=i, mac_clear=(i==0).
//  i increments each RUN cycle, wraps at N_IN-1 to 0 and increments o.
//  mac_en/mac_clear/coef_addr/in_sel are 0 outside RUN.
//  Last tap of bus o (i=N_IN-1) is delayed MAC_LATENCY cycles through a shift register;
//  on emergence: out_wr=1, out_sel=o for exactly one cycle.
//  Final out_wr at cycle N_IN*N_OUT+MAC_LATENCY (66 at defaults); done=1 in that same cycle.
//  busy falls the cycle after done; state is IDLE then.
//  Start while busy (including the done cycle): ignored, no restart; overrun set to 1
//  and held until reset. Start in IDLE never affects overrun.
//  Reset mid-frame: sequencing aborts in the same edge; no out_wr/done after reset deasserts.
//  out_sel holds last value between strobes (reset 0); consumers qualify it with out_wr.
// TESTING
//  1 Reset held 3 cycles, release -> all outputs 0, busy=0, no mac_en for 100 idle cycles.
//  2 Single start at cycle 0 (defaults) -> mac_en cycles 1..64, coef_addr 0..63 in order,
//    mac_clear at cycles 1,9,..,57; out_wr at cycles 10,18,..,66 with out_sel 0..7;
//    done only at 66; busy high cycles 1..66.
//  3 Second start at cycle 30 and at cycle 66 -> sequence unchanged, overrun=1 from cycle 31 on.
//  4 Start at cycle 67 (first IDLE cycle) after a frame -> clean second frame, overrun stays 0.
//  5 Reset at cycle 20 mid-frame -> outputs 0 next cycle, no out_wr/done; new start runs full frame.
//  6 Params N_IN=4, N_OUT=2, MAC_LATENCY=3 -> 8 taps, out_wr at cycles 7 and 11, done at 11.

Source files
------------

// File: rtl/mix_sequencer.sv
// Tap sequencer for the shared MAC: one N_IN x N_OUT gain matrix per frame.
// Issues one tap per cycle and strobes each bus result after the MAC latency.
module mix_sequencer #(
  parameter int N_IN        = 8,
  parameter int N_OUT       = 8,
  parameter int MAC_LATENCY = 2,
  localparam int AW = $clog2(N_IN * N_OUT),
  localparam int IW = $clog2(N_IN),
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] coef_addr,
  output logic [IW-1:0] in_sel,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          out_wr,
  output logic [OW-1:0] out_sel,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] i;
  logic [OW-1:0] o;
  logic [CW-1:0] dcnt;
  logic          last_tap;
  logic          em_v;
  logic [OW-1:0] em_o;

  assign last_tap = (state == RUN) && (i == IW'(N_IN - 1));

  // Final out_wr/out_sel flops are the last pipeline stage
  if (MAC_LATENCY == 1) begin : g_l1
    assign em_v = last_tap;
    assign em_o = o;
  end else begin : g_pipe
    logic [MAC_LATENCY-2:0] pv;
    logic [OW-1:0]          po [MAC_LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        pv <= '0;
        for (int k = 0; k < MAC_LATENCY - 1; k++)
          po[k] <= '0;
      end else begin
        pv[0] <= last_tap;
        po[0] <= o;
        for (int k = 1; k < MAC_LATENCY - 1; k++) begin
          pv[k] <= pv[k-1];
          po[k] <= po[k-1];
        end
      end
    end

    assign em_v = pv[MAC_LATENCY-2];
    assign em_o = po[MAC_LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      i         <= '0;
      o         <= '0;
      dcnt      <= '0;
      coef_addr <= '0;
      in_sel    <= '0;
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
      out_wr    <= 1'b0;
      out_sel   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_wr <= em_v;
      done   <= em_v && (em_o == OW'(N_OUT - 1));
      if (em_v)
        out_sel <= em_o;
      if (start && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            i         <= '0;
            o         <= '0;
            mac_en    <= 1'b1;
            mac_clear <= 1'b1;
            coef_addr <= '0;
            in_sel    <= '0;
          end
        end
        RUN: begin
          if (i == IW'(N_IN - 1)) begin
            i <= '0;
            if (o == OW'(N_OUT - 1)) begin
              state     <= DRAIN;
              o         <= '0;
              dcnt      <= '0;
              mac_en    <= 1'b0;
              mac_clear <= 1'b0;
              coef_addr <= '0;
              in_sel    <= '0;
            end else begin
              o         <= o + OW'(1);
              mac_clear <= 1'b1;
              coef_addr <= coef_addr + AW'(1);
              in_sel    <= '0;
            end
          end else begin
            i         <= i + IW'(1);
            mac_clear <= 1'b0;
            coef_addr <= coef_addr + AW'(1);
            in_sel    <= i + IW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == CW'(MAC_LATENCY - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_sequencer.sv
// Bench for mix_sequencer: default-size frames plus a small
// 4x2 / latency-3 instance driven from a vector table.
module tb_mix_sequencer;

  logic clk = 1'b0;
  logic reset, start, start2;

  always #5 clk = ~clk;

  logic       busy1, en1, clr1, wr1, done1, ovr1;
  logic [5:0] coef1;
  logic [2:0] is1, os1;

  logic       busy2, en2, clr2, wr2, done2, ovr2;
  logic [2:0] coef2;
  logic [1:0] is2;
  logic       os2;

  mix_sequencer u_dut1 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy1), .coef_addr(coef1), .in_sel(is1),
    .mac_en(en1), .mac_clear(clr1), .out_wr(wr1),
    .out_sel(os1), .done(done1), .overrun(ovr1)
  );

  mix_sequencer #(.N_IN(4), .N_OUT(2), .MAC_LATENCY(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .busy(busy2), .coef_addr(coef2), .in_sel(is2),
    .mac_en(en2), .mac_clear(clr2), .out_wr(wr2),
    .out_sel(os2), .done(done2), .overrun(ovr2)
  );

  int checks = 0;
  int errors = 0;
  int exp_sel = 0;

  typedef struct {
    bit       st;
    bit       b;
    bit       en;
    bit       clr;
    bit [2:0] a;
    bit [1:0] is;
    bit       wr;
    bit       os;
    bit       d;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", nm, c, act, exp);
    end
  endtask

  function automatic logic [31:0] pack1();
    return {14'd0, busy1, en1, clr1, coef1, is1, wr1, os1, done1, ovr1};
  endfunction

  function automatic logic [31:0] exp1(
    logic b, logic en, logic clr, logic [5:0] a, logic [2:0] is,
    logic wr, logic [2:0] os, logic d, logic ov);
    return {14'd0, b, en, clr, a, is, wr, os, d, ov};
  endfunction

  function automatic logic [31:0] pack2();
    return {20'd0, busy2, en2, clr2, coef2, is2, wr2, os2, done2, ovr2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    exp_sel = 0;
  endtask

  task automatic idle_check(string nm, int n);
    for (int c = 0; c < n; c++) begin
      chk(nm, c, pack1(), exp1(0, 0, 0, 0, 0, 0, 3'(exp_sel), 0, 0));
      step();
    end
  endtask

  // Entered at cycle 0 (IDLE); returns sampled at cycle 67.
  task automatic frame(string nm, int s1, int s2, bit ov0);
    logic       en, clr, wr, d, b, ov;
    logic [5:0] a;
    logic [2:0] is;
    ov = ov0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      en  = (c <= 64);
      a   = en ? 6'(c - 1) : 6'd0;
      is  = en ? 3'((c - 1) % 8) : 3'd0;
      clr = en && ((c - 1) % 8 == 0);
      wr  = (c >= 10) && (c <= 66) && ((c - 10) % 8 == 0);
      if (wr) exp_sel = (c - 10) / 8;
      d   = (c == 66);
      b   = (c <= 66);
      if (c == s1 + 1 || c == s2 + 1) ov = 1'b1;
      chk(nm, c, pack1(), exp1(b, en, clr, a, is, wr, 3'(exp_sel), d, ov));
      start = (c == s1) || (c == s2);
      if (c < 67) step();
    end
    start = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 2, 2, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 3, 3, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 4, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 5, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 6, 2, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 7, 3, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

    do_reset();
    step();
    idle_check("idle", 100);

    frame("frame", -1, -1, 0);
    frame("b2b", -1, -1, 0);
    frame("ovr", 30, 66, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    chk("mid_en", 20, {31'd0, en1}, 32'd1);
    reset = 1'b1;
    step();
    exp_sel = 0;
    chk("rst_mid", 21, pack1(), exp1(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    idle_check("post_rst", 80);
    frame("refr", -1, -1, 0);

    for (int k = 0; k < 13; k++) begin
      chk("tbl", k, pack2(),
          {20'd0, tbl[k].b, tbl[k].en, tbl[k].clr, tbl[k].a,
           tbl[k].is, tbl[k].wr, tbl[k].os, tbl[k].d, 1'b0});
      start2 = tbl[k].st;
      step();
    end
    start2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
